// File: rtl/ecp5pll_phase_ctrl.sv
// Sequencer for the ECP5 PLL dynamic phase-shift pins: setup, spaced phasestep pulses, optional load, done.
// Optional LOCKWAIT state (wait for stable pll_locked before done) is enabled by ECP5PLL_PHASE_LOCKWAIT_EN.
module ecp5pll_phase_ctrl #(
  parameter int STEP_W    = 10,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int LOCK_CYC  = 16
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  input  logic              req_dir,
  input  logic [STEP_W-1:0] req_steps,
  input  logic              req_load,
  output logic [1:0]        phasesel,
  output logic              phasedir,
  output logic              phasestep,
  output logic              phaseloadreg,
  input  logic              pll_locked,
  output logic              busy,
  output logic              done
);

  localparam int TMAX  = (SETUP_CYC > PULSE_CYC + GAP_CYC) ? SETUP_CYC : PULSE_CYC + GAP_CYC;
  localparam int TMR_W = $clog2(TMAX + 1);

  localparam logic [TMR_W-1:0] T_SETUP    = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] T_PULSE    = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] T_GAP      = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] T_LOAD     = TMR_W'(PULSE_CYC + GAP_CYC - 1);
  localparam logic [TMR_W-1:0] T_LOAD_LOW = TMR_W'(GAP_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_GAP,
    S_LOAD,
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
    S_LOCKWAIT,
`endif
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                load_q, load_d;
  logic [1:0]          sel_q, sel_d;
  logic                dir_q, dir_d;
  logic                step_q, step_d;
  logic                ldreg_q, ldreg_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  state_t              finish_st;

`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
  localparam int LK_W = $clog2(LOCK_CYC + 1);
  localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_CYC - 1);
  logic [LK_W-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_pll_locked;
  assign unused_pll_locked = pll_locked;
`endif

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    steps_d = steps_q;
    load_d  = load_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
    lock_cnt_d = lock_cnt_q;
    finish_st  = S_LOCKWAIT;
`else
    finish_st  = S_DONE;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          load_d  = req_load;
          if (req_steps != '0) begin
            state_d = S_SETUP;
            tmr_d   = T_SETUP;
          end else if (req_load) begin
            state_d = S_LOAD;
            tmr_d   = T_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SETUP: begin
        if (tmr_q == '0) begin
          state_d = S_PULSE;
          tmr_d   = T_PULSE;
        end else tmr_d = tmr_q - TMR_W'(1);
      end
      S_PULSE: begin
        if (tmr_q == '0) begin
          state_d = S_GAP;
          tmr_d   = T_GAP;
          steps_d = steps_q - STEP_W'(1);
        end else tmr_d = tmr_q - TMR_W'(1);
      end
      S_GAP: begin
        if (tmr_q == '0) begin
          if (steps_q != '0) begin
            state_d = S_PULSE;
            tmr_d   = T_PULSE;
          end else if (load_q) begin
            state_d = S_LOAD;
            tmr_d   = T_LOAD;
          end else state_d = finish_st;
        end else tmr_d = tmr_q - TMR_W'(1);
      end
      // LOAD covers the high pulse and the trailing low gap with one timer run
      S_LOAD: begin
        if (tmr_q == '0) state_d = finish_st;
        else tmr_d = tmr_q - TMR_W'(1);
      end
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      S_LOCKWAIT: begin
        if (pll_locked) begin
          if (lock_cnt_q == LOCK_LAST) state_d = S_DONE;
          else lock_cnt_d = lock_cnt_q + LK_W'(1);
        end else lock_cnt_d = '0;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
    if (state_q != S_LOCKWAIT) lock_cnt_d = '0;
`endif
    step_d  = (state_d == S_PULSE);
    ldreg_d = (state_d == S_LOAD) && (tmr_d >= T_LOAD_LOW);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      steps_q <= '0;
      load_q  <= 1'b0;
      sel_q   <= 2'b00;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      ldreg_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      lock_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      steps_q <= steps_d;
      load_q  <= load_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      ldreg_q <= ldreg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
`ifdef ECP5PLL_PHASE_LOCKWAIT_EN
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  assign req_ready    = ready_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = step_q;
  assign phaseloadreg = ldreg_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Scoreboard bench for ecp5pll_phase_ctrl: driver pushes expected timing per request, negedge monitor checks at done.
module tb_ecp5pll_phase_ctrl;

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_sel = 2'b00;
  logic       req_dir = 1'b0;
  logic [9:0] req_steps = '0;
  logic       req_load = 1'b0;
  logic [1:0] phasesel;
  logic       phasedir, phasestep, phaseloadreg;
  logic       pll_locked = 1'b0;
  logic       busy, done;

  ecp5pll_phase_ctrl dut (
    .clk_i(clk_i), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .req_load(req_load),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep), .phaseloadreg(phaseloadreg),
    .pll_locked(pll_locked), .busy(busy), .done(done)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int t0; int done_at; int nstep; int first_step; int load_at; int sel; int dir;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic check(string name, int act, int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // monitor
  int m_nstep, m_first, m_w, m_nload, m_lfirst, m_lw;
  bit m_in, m_lin;

  task automatic mon_clear();
    m_nstep = 0; m_first = -1; m_w = 0; m_in = 0;
    m_nload = 0; m_lfirst = -1; m_lw = 0; m_lin = 0;
  endtask

  initial mon_clear();

  always @(negedge clk_i) begin
    if (reset) begin
      mon_clear();
    end else begin
      if (phasestep) begin
        if (!m_in) begin
          if (m_nstep == 0) m_first = cyc;
          m_nstep++;
          m_w = 0;
        end
        m_w++;
      end else if (m_in) check("step_width", m_w, 4);
      m_in = phasestep;
      if (phaseloadreg) begin
        if (!m_lin) begin
          if (m_nload == 0) m_lfirst = cyc;
          m_nload++;
          m_lw = 0;
        end
        m_lw++;
      end else if (m_lin) check("load_width", m_lw, 4);
      m_lin = phaseloadreg;
      if (busy && q.size() > 0) begin
        check("phasesel_busy", int'(phasesel), q[0].sel);
        check("phasedir_busy", int'(phasedir), q[0].dir);
      end
      if (done) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: done=1 with no request pending (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("done_cycle", cyc, e.done_at);
          check("busy_at_done", int'(busy), 1);
          check("step_count", m_nstep, e.nstep);
          check("first_step_cycle", m_first, e.first_step);
          check("load_count", m_nload, (e.load_at >= 0) ? 1 : 0);
          check("load_cycle", m_lfirst, e.load_at);
        end
        mon_clear();
      end
    end
  end

  // driver: caller is at a negedge
  task automatic send(input int sel, input int dir, input int steps, input int load, output int t0);
    exp_t x;
    int body;
    req_sel   = 2'(sel);
    req_dir   = dir[0];
    req_steps = 10'(steps);
    req_load  = load[0];
    req_valid = 1'b1;
    t0 = -1;
    for (int i = 0; i < 20000 && t0 < 0; i++) begin
      if (req_ready) begin
        t0 = cyc;
        body = (steps > 0) ? 4 + 8 * steps : 0;
        x.t0 = t0;
        x.nstep = steps;
        x.first_step = (steps > 0) ? t0 + 5 : -1;
        x.load_at = load ? t0 + 1 + body : -1;
        x.done_at = t0 + 1 + body + (load ? 8 : 0);
        x.sel = sel;
        x.dir = dir;
        q.push_back(x);
      end else @(negedge clk_i);
    end
    if (t0 < 0) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: request sel=%0d steps=%0d never accepted", sel, steps);
    end
    @(negedge clk_i);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 12000 && !ok; i++) begin
      if (q.size() == 0 && !busy && req_ready) ok = 1;
      else @(negedge clk_i);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0d pending=%0d", busy, q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int t, ta, tb2, ndone;
  bit seen;

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_phasestep", int'(phasestep), 0);
    check("rst_phaseloadreg", int'(phaseloadreg), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_phasesel", int'(phasesel), 0);
    check("rst_phasedir", int'(phasedir), 0);
    reset = 1'b0;
    @(negedge clk_i);
    check("idle_ready", int'(req_ready), 1);
    check("idle_busy", int'(busy), 0);

    send(2, 1, 3, 0, t);
    check("sel_after_accept", int'(phasesel), 2);
    check("dir_after_accept", int'(phasedir), 1);
    wait_idle();

    send(0, 0, 0, 0, t); wait_idle();
    send(1, 1, 0, 1, t); wait_idle();
    send(1, 0, 2, 1, t); wait_idle();
    send(3, 0, 1023, 0, t); wait_idle();

    // back-to-back: second request held valid while the first is busy
    send(1, 0, 1, 0, ta);
    send(3, 1, 2, 1, tb2);
    check("b2b_accept_cycle", tb2, ta + 14);
    wait_idle();

    // async reset in the middle of a pulse
    @(negedge clk_i);
    send(2, 1, 2, 0, t);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (phasestep) seen = 1;
      else @(negedge clk_i);
    end
    check("abort_pulse_seen", int'(seen), 1);
    #2 reset = 1'b1;
    q.delete();
    #1;
    check("abort_phasestep", int'(phasestep), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_phasesel", int'(phasesel), 0);
    repeat (2) @(negedge clk_i);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_ready", int'(req_ready), 1);

    send(0, 1, 1, 0, t); wait_idle();
    check("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
Name: ecp5pll_phase_ctrl

Overview:
- Sequencer that drives the dynamic phase-shift pins of the ECP5 PLL wrapper: phasesel, phasedir, phasestep and phaseloadreg.
- Accepts a request over a valid/ready handshake: channel, direction, step count and optional load.
- Emits correctly timed phasestep pulses with setup and gap spacing, then pulses done.
- Sits between user logic (DDR/video/SDRAM clock-alignment calibration) and the PLL wrapper instance.

Parameters:
- STEP_W, 10, width of req_steps; max request is 2^STEP_W-1 steps.
- SETUP_CYC, 4, cycles phasesel/phasedir are held stable before the first phasestep; minimum 1.
- PULSE_CYC, 4, cycles phasestep is held high per step; minimum 1.
- GAP_CYC, 4, cycles phasestep is held low after each pulse; minimum 1.
- LOCK_CYC, 16, consecutive pll_locked-high cycles required in LOCKWAIT; used only with the macro.

Ports:
- clk_i  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_sel  in  2  channel, wrapper-level encoding, passed through unmodified.
- req_dir  in  1  0 = delay (lag), 1 = advance; passed to phasedir.
- req_steps  in  STEP_W  number of phasestep pulses.
- req_load  in  1  issue a phaseloadreg pulse after the steps.
- phasesel  out  2  to PLL wrapper.
- phasedir  out  1  to PLL wrapper.
- phasestep  out  1  to PLL wrapper.
- phaseloadreg  out  1  to PLL wrapper.
- pll_locked  in  1  PLL lock status; ignored without the macro.
- busy  out  1  high from accept until done, inclusive.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered. On reset (asynchronous), immediately:
  - phasesel=0, phasedir=0, phasestep=0, phaseloadreg=0, busy=0, done=0.
  - state=IDLE; req_ready=1 once reset deasserts.
- Reset mid-operation aborts the sequence. Any pulse in progress is truncated. No done is emitted.
- States: IDLE, SETUP, PULSE, GAP, LOAD, [LOCKWAIT], DONE. One down-counter handles timing; one step counter holds the remaining steps.
- req_ready = (state==IDLE). Accept occurs on req_valid&&req_ready at clock edge t0.
- At accept:
  - Latch phasesel=req_sel and phasedir=req_dir; hold them until the next accept.
  - Latch the step count and the load flag.
  - Set busy=1.
- Next state after accept:
  - steps>0: SETUP.
  - steps==0 and load=1: LOAD.
  - steps==0 and load=0: DONE.
- SETUP: lasts SETUP_CYC cycles, then PULSE.
- PULSE: phasestep=1 for PULSE_CYC cycles, then GAP.
- GAP: phasestep=0 for GAP_CYC cycles. Decrement the step count on GAP entry. On exit:
  - remaining>0: PULSE.
  - remaining==0 and load=1: LOAD.
  - otherwise: DONE (or LOCKWAIT with the macro).
- LOAD: phaseloadreg=1 for PULSE_CYC cycles, then GAP_CYC low cycles, then DONE (or LOCKWAIT with the macro).
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- Timing, no load, macro off: done is high at cycle t0 + 1 + SETUP_CYC + N*(PULSE_CYC+GAP_CYC).
- Timing, N==0 and no load: done is high at t0+1.
- Back-to-back: a request presented during busy stalls (ready=0). The earliest next accept is the first IDLE cycle after DONE.
- req_* inputs are sampled only at accept; changes while busy are ignored.
- Counters are sized so that STEP_W all-ones steps complete without wrap. The count is never negative.

Optional Feature:
- Macro: ECP5PLL_PHASE_LOCKWAIT_EN.
- Defined: after the last GAP (or after LOAD), enter LOCKWAIT. Stay there until pll_locked has been high for LOCK_CYC consecutive cycles; any low sample restarts the count. Then go to DONE. No timeout.
- Undefined: LOCKWAIT is absent and pll_locked is unused.

Test Plan (defaults, macro off unless stated):
- Reset held, then released; idle → all outputs 0, req_ready=1; async reset asserted mid-PULSE → phasestep drops the same cycle, no done.
- req_sel=2, req_dir=1, req_steps=3 at t0 → phasesel=2 and phasedir=1 from t0+1; exactly three 4-cycle phasestep pulses, the first starting t0+5; done at t0+29.
- req_steps=0, req_load=0 → done at t0+1, no phasestep.
- req_steps=0, req_load=1 → single 4-cycle phaseloadreg pulse at t0+1..t0+4, done at t0+9.
- Second request held valid during busy → not accepted until the IDLE cycle after done; its sel/dir are not applied early.
- Macro on, req_steps=1, pll_locked low then high at t0+20 → done at t0+20+16.
